// File: rtl/regfile_mp_scoreboard_if.sv
// regfile_mp_scoreboard_if: read, write and claim bundle between the pipeline and the register file
interface regfile_mp_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD = 2,
  parameter int NWRITE = 2
);
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0] rd_pending;
  logic [NWRITE-1:0] wr_en;
  logic [NWRITE*ADDR_W-1:0] wr_addr;
  logic [NWRITE*DATA_W-1:0] wr_data;
  logic claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic [ADDR_W:0] pending_count;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input rd_data, rd_pending, pending_count
  );
  modport slave (
    input rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_pending, pending_count
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: multi-port register file with write bypass and per-register pending bits
module regfile_mp_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD = 2,
  parameter int NWRITE = 2
) (
  input logic clk,
  input logic reset,
  regfile_mp_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_nxt;
  logic [ADDR_W:0] cnt;
  // later write ports overwrite earlier ones so the youngest stage wins a same-index collision
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else
      for (int w = 0; w < NWRITE; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*ADDR_W +: ADDR_W] != '0)
          mem[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
  // writes retire their producer, then a same-cycle claim re-marks the destination as in flight
  always_comb begin
    pend_nxt = pend;
    for (int w = 0; w < NWRITE; w++)
      if (bus.wr_en[w]) pend_nxt[bus.wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    if (bus.claim_en) pend_nxt[bus.claim_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end
  // scoreboard state and its registered population count
  always_ff @(posedge clk)
    if (reset) begin
      pend <= '0;
      cnt <= '0;
    end else begin
      pend <= pend_nxt;
      cnt <= (ADDR_W+1)'($countones(pend_nxt));
    end
  assign bus.pending_count = cnt;
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic hit;
    assign a = bus.rd_addr[k*ADDR_W +: ADDR_W];
    // the youngest enabled write to the same index bypasses the stored value
    always_comb begin
      d = mem[a];
      hit = 1'b0;
      for (int w = 0; w < NWRITE; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*ADDR_W +: ADDR_W] == a) begin
          d = bus.wr_data[w*DATA_W +: DATA_W];
          hit = 1'b1;
        end
    end
    assign bus.rd_data[k*DATA_W +: DATA_W] = a == '0 ? '0 : d;
    assign bus.rd_pending[k] = a != '0 && pend[a] && !hit;
  end
`ifdef DEBUG
  // trace every committed write
  always_ff @(posedge clk)
    if (!reset)
      for (int w = 0; w < NWRITE; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*ADDR_W +: ADDR_W] != '0)
          $display("%0t wr port %0d idx %0d data %h", $time, w,
                   bus.wr_addr[w*ADDR_W +: ADDR_W], bus.wr_data[w*DATA_W +: DATA_W]);
`endif
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb_regfile_mp_scoreboard: directed checks of reads, bypass, zero register and scoreboard
module tb_regfile_mp_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  regfile_mp_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) bus ();
  regfile_mp_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.wr_en = 2'b00;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.claim_en = 1'b0;
    bus.claim_addr = '0;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    bus.rd_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk("reset_rd0", bus.rd_data[31:0], 32'h0);
      chk("reset_rd1", bus.rd_data[63:32], 32'h0);
      chk("reset_pend", {30'h0, bus.rd_pending}, 32'h0);
    end
    chk("reset_count", {26'h0, bus.pending_count}, 32'h0);
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd5};
    bus.wr_data = {32'h0, 32'hDEADBEEF};
    rd(5'd5, 5'd0);
    chk("bypass_5", bus.rd_data[31:0], 32'hDEADBEEF);
    tick();
    idle();
    rd(5'd5, 5'd5);
    chk("stored_5_p0", bus.rd_data[31:0], 32'hDEADBEEF);
    chk("stored_5_p1", bus.rd_data[63:32], 32'hDEADBEEF);
    bus.wr_en = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {32'h22222222, 32'h11111111};
    rd(5'd7, 5'd7);
    chk("bypass_7_prio", bus.rd_data[63:32], 32'h22222222);
    tick();
    idle();
    rd(5'd7, 5'd5);
    chk("stored_7_prio", bus.rd_data[31:0], 32'h22222222);
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd0};
    bus.wr_data = {32'h0, 32'hFFFFFFFF};
    bus.claim_en = 1'b1;
    bus.claim_addr = 5'd0;
    rd(5'd0, 5'd0);
    chk("zero_bypass", bus.rd_data[31:0], 32'h0);
    chk("zero_pend_now", {30'h0, bus.rd_pending}, 32'h0);
    tick();
    idle();
    rd(5'd0, 5'd0);
    chk("zero_stored", bus.rd_data[31:0], 32'h0);
    chk("zero_pend", {30'h0, bus.rd_pending}, 32'h0);
    chk("zero_count", {26'h0, bus.pending_count}, 32'h0);
    bus.claim_en = 1'b1;
    bus.claim_addr = 5'd3;
    tick();
    chk("claim3_count", {26'h0, bus.pending_count}, 32'd1);
    bus.claim_addr = 5'd4;
    tick();
    idle();
    chk("claim4_count", {26'h0, bus.pending_count}, 32'd2);
    rd(5'd3, 5'd4);
    chk("pend_3_4", {30'h0, bus.rd_pending}, 32'b11);
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd3};
    bus.wr_data = {32'h0, 32'hA5};
    rd(5'd3, 5'd4);
    chk("pend_3_cleared_now", {30'h0, bus.rd_pending}, 32'b10);
    chk("bypass_3", bus.rd_data[31:0], 32'hA5);
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("write3_count", {26'h0, bus.pending_count}, 32'd1);
    chk("pend_after_w3", {30'h0, bus.rd_pending}, 32'b10);
    chk("stored_3", bus.rd_data[31:0], 32'hA5);
    bus.claim_en = 1'b1;
    bus.claim_addr = 5'd10;
    rd(5'd10, 5'd0);
    chk("claim10_not_yet", {30'h0, bus.rd_pending}, 32'b00);
    tick();
    idle();
    rd(5'd10, 5'd0);
    chk("claim10_seen", {30'h0, bus.rd_pending}, 32'b01);
    chk("claim10_count", {26'h0, bus.pending_count}, 32'd2);
    bus.claim_en = 1'b1;
    bus.claim_addr = 5'd9;
    bus.wr_en = 2'b10;
    bus.wr_addr = {5'd9, 5'd0};
    bus.wr_data = {32'h77, 32'h0};
    tick();
    idle();
    rd(5'd9, 5'd0);
    chk("claim_wins_pend", {30'h0, bus.rd_pending}, 32'b01);
    chk("claim_wins_data", bus.rd_data[31:0], 32'h77);
    chk("claim_wins_count", {26'h0, bus.pending_count}, 32'd3);
    bus.claim_en = 1'b1;
    bus.claim_addr = 5'd10;
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd12};
    bus.wr_data = {32'h0, 32'h12345678};
    tick();
    idle();
    rd(5'd12, 5'd10);
    chk("reclaim_count", {26'h0, bus.pending_count}, 32'd3);
    chk("nonpend_write", bus.rd_data[31:0], 32'h12345678);
    chk("nonpend_bits", {30'h0, bus.rd_pending}, 32'b10);
    reset = 1'b1;
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd9};
    bus.wr_data = {32'h0, 32'h55};
    bus.claim_en = 1'b1;
    bus.claim_addr = 5'd20;
    rd(5'd9, 5'd5);
    chk("reset_cycle_bypass", bus.rd_data[31:0], 32'h55);
    chk("reset_cycle_stored", bus.rd_data[63:32], 32'hDEADBEEF);
    tick();
    reset = 1'b0;
    idle();
    rd(5'd9, 5'd20);
    chk("post_reset_9", bus.rd_data[31:0], 32'h0);
    chk("post_reset_pend", {30'h0, bus.rd_pending}, 32'b00);
    chk("post_reset_count", {26'h0, bus.pending_count}, 32'd0);
    rd(5'd5, 5'd7);
    chk("post_reset_5", bus.rd_data[31:0], 32'h0);
    chk("post_reset_7", bus.rd_data[63:32], 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
Parametrised multi-port general register file for the pipelined core. It replaces the fixed 2-read/1-write 32x32 file.
- NREAD combinational read ports and NWRITE write ports.
- Same-cycle write-to-read bypass.
- Per-register pending (scoreboard) bits, so the hazard unit can stall on in-flight destinations.
- Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NREAD, 2, number of read ports (1..4)
NWRITE, 2, number of write ports (1..2); higher index = younger pipeline stage = higher priority

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clock clk
rd_addr  in  NREAD*ADDR_W  packed read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NREAD*DATA_W  packed read data, combinational
rd_pending  out  NREAD  per-port: addressed register has an outstanding claim not satisfied this cycle
wr_en  in  NWRITE  per-port write enable
wr_addr  in  NWRITE*ADDR_W  packed write indices
wr_data  in  NWRITE*DATA_W  packed write data
claim_en  in  1  issue stage marks claim_addr as pending
claim_addr  in  ADDR_W  destination being claimed
pending_count  out  ADDR_W+1  registered number of pending registers

Behaviour:
- Storage: 2**ADDR_W entries x DATA_W. Entry 0 always reads 0.
- Writes, claims and clears to index 0 are ignored.
- Reset (synchronous, priority over everything):
  - all entries <= 0
  - all pending bits <= 0
  - pending_count <= 0
- Write:
  - At posedge, each port with wr_en=1 and wr_addr!=0 updates its entry.
  - Two ports writing the same index in the same cycle: port NWRITE-1 wins.
- Read (combinational, zero latency):
  - rd_addr=0 -> 0.
  - Otherwise, if any write port targets that index this cycle with wr_en=1, return the highest-priority such wr_data (bypass).
  - Otherwise return the stored value.
- Pending bits, at posedge:
  - Any enabled write to index i clears pending[i].
  - claim_en with claim_addr=i sets pending[i].
  - Claim and write to the same index in the same cycle: set wins (the new producer is still in flight).
- rd_pending[k]:
  - Equals pending[rd_addr[k]] & ~(any enabled write to rd_addr[k] this cycle).
  - Forced 0 for index 0.
  - A same-cycle claim does not affect rd_pending until the next cycle.
- pending_count: registered population count of the pending bits after the update. It reflects state one cycle after a claim or write. It never exceeds 2**ADDR_W-1.
- Claiming an already-pending register: bit stays 1, count unchanged.
- Writing a non-pending register: legal; data updates, bit stays 0.
- Reset asserted mid-operation: cancels the same-cycle writes and claims. Reads during the reset cycle still return pre-reset storage/bypass values.
- Simulation-only: when DEBUG is defined, each committed write prints time, port, index and data.

Test Plan:
- Reset, then read all indices on all ports -> every rd_data=0, rd_pending=0, pending_count=0.
- Write port0 idx 5 = 0xDEADBEEF; next cycle rd_addr[0]=5 -> 0xDEADBEEF. Same cycle as the write -> bypass already returns 0xDEADBEEF.
- Port0 idx 7 = 0x11111111 and port1 idx 7 = 0x22222222 in the same cycle -> bypass and later stored value both 0x22222222.
- Write idx 0 = 0xFFFFFFFF, claim idx 0 -> rd_data=0, rd_pending=0, pending_count=0.
- Claim idx 3 and idx 4 on consecutive cycles -> pending_count 1 then 2, rd_pending for idx 3 = 1. Then write idx 3 = 0xA5 -> rd_pending=0 that cycle, rd_data=0xA5, next pending_count=1.
- Claim idx 9 while port1 writes idx 9 -> pending[9] remains 1. Then assert reset together with a write to idx 9 = 0x55 -> after edge idx 9 reads 0, pending_count=0.
